// File: rtl/uart_pkg.sv
// Shared UART receiver types and default configuration constants.
package uart_pkg;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver; define UART_RX_PARITY_EN to add an even-parity bit
// after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 sample;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Full bit period elapsed: centre of a data/parity/stop bit.
  assign sample = tick && (tick_cnt == TICK_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick && state != IDLE && state != WAIT_IDLE) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : TW'(tick_cnt + 1'b1);
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
            busy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
          end
        end
        // Mid-start-bit check rejects glitches shorter than half a bit.
        START: begin
          if (tick && tick_cnt == TICK_MID) begin
            tick_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= BW'(bit_cnt + 1'b1);
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            par_bad <= (^shreg) ^ rx_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample) begin
            data <= shreg;
            if (rx_s) begin
              valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
        end
        // Line held low (break): wait for it to return high before rearming.
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 8 data bits, 16x oversampling, tick every 4 clocks.
module tb_uart_rx;

  localparam int unsigned DB           = 8;
  localparam int unsigned OS           = 16;
  localparam int unsigned CLK_PER_TICK = 4;
  localparam int unsigned BIT_CLKS     = OS * CLK_PER_TICK;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tcnt = 0;
  always @(negedge clk) begin
    if (tcnt == CLK_PER_TICK - 1) begin
      tcnt = 0;
      tick = 1'b1;
    end else begin
      tcnt = tcnt + 1;
      tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Queues the expected outcome, then drives one frame on rx.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    exp_t e;
    e.d  = d;
    e.v  = stop;
    e.fe = ~stop;
    e.pe = stop & PAR_EN & ~par_ok;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par_ok ? ^d : ~^d);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  logic [DB-1:0] last_data = '0;
  logic          prev_pulse = 1'b0;
  logic          mon_pulse;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_data  = '0;
      prev_pulse = 1'b0;
    end else begin
      mon_pulse = valid | frame_err | parity_err;
      if (prev_pulse) begin
        check("single_pulse", mon_pulse, 0);
      end else if (mon_pulse) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {valid, frame_err, parity_err}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("valid", valid, mon_e.v);
          check("frame_err", frame_err, mon_e.fe);
          check("parity_err", parity_err, mon_e.pe);
          check("data", data, mon_e.d);
          check("valid_fe_excl", valid & frame_err, 0);
          if (valid) check("busy_at_valid", busy, 0);
        end
        last_data = data;
      end else begin
        check("data_hold", data, last_data);
      end
      prev_pulse = mon_pulse;
    end
  end

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // Good frame 0x55
    send_frame(8'h55, 1'b1, 1'b1);
    send_bit(1'b1);
    drain("drain_55");
    check("idle_after_55", busy, 0);

    // Start-bit glitch of 3 ticks
    rx = 1'b0;
    repeat (3 * CLK_PER_TICK) @(negedge clk);
    check("glitch_busy", busy, 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_idle", busy, 0);

    // Frame error with line held low for 40 ticks
    send_frame(8'hA3, 1'b0, 1'b1);
    repeat ((40 - OS) * CLK_PER_TICK) @(negedge clk);
    check("fe_seen", exp_q.size(), 0);
    check("wait_idle_busy", busy, 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("break_release_idle", busy, 0);

    // Parity mismatch (flagged only with parity enabled)
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("drain_07");

    // Reset during bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_data", data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("post_rst_idle", busy, 0);
    send_frame(8'h12, 1'b1, 1'b1);
    send_bit(1'b1);
    drain("drain_12");

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    send_bit(1'b1);
    drain("drain_b2b");
    check("final_data", data, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
